// File: rtl/audio_fade_pkg.sv
// Shared types and constants for the audio fade conditioning block.
package audio_fade_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned GAIN_W   = 9;
    localparam int unsigned PROD_W   = 25;

    localparam logic [GAIN_W-1:0]   GAIN_UNITY = 9'd256;
    localparam logic [SAMPLE_W-1:0] QUIESCENT  = 16'h8000;

    typedef enum logic [1:0] {
        MUTE     = 2'd0,
        FADE_IN  = 2'd1,
        RUN      = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

endpackage

// File: rtl/audio_gain_channel.sv
// One audio channel: sample holding register, gain multiply, offset-binary output register.
module audio_gain_channel
    import audio_fade_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_stb,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [GAIN_W-1:0]   gain,
    output logic [SAMPLE_W-1:0] d_out
);

    logic signed [SAMPLE_W-1:0] sample_q;
    logic signed [PROD_W-1:0]   sample_ext;
    logic signed [PROD_W-1:0]   gain_ext;
    logic signed [PROD_W-1:0]   prod;
    logic        [SAMPLE_W-1:0] scaled;
    logic                       unused_prod_bits;

    // Capture a new sample on the strobe, otherwise hold the previous one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= '0;
        end else if (sample_stb) begin
            sample_q <= sample_in;
        end
    end

    // Signed sample times non-negative gain; floor shift by 8 makes 256 an exact passthrough.
    always_comb begin
        sample_ext = PROD_W'(sample_q);
        gain_ext   = PROD_W'({1'b0, gain});
        prod       = sample_ext * gain_ext;
        scaled     = prod[23:8];
    end

    // Sign bit and fraction bits are not part of the scaled result.
    assign unused_prod_bits = ^{prod[PROD_W-1], prod[7:0]};

    // Register the offset-binary result every clock so gain changes show up one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_out <= QUIESCENT;
        end else begin
            d_out <= {~scaled[SAMPLE_W-1], scaled[SAMPLE_W-2:0]};
        end
    end

endmodule

// File: rtl/audio_fade_prep.sv
// Click-free fade-in/fade-out conditioning of stereo audio ahead of the sigma-delta stage.
module audio_fade_prep
    import audio_fade_pkg::*;
#(
    parameter int unsigned RAMP_SHIFT = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_stb,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    input  logic                enable,
    input  logic                terminate,
    output logic [SAMPLE_W-1:0] d_l,
    output logic [SAMPLE_W-1:0] d_r,
    output logic [GAIN_W-1:0]   gain,
    output logic                muted,
    output logic                active
);

    fade_state_t             state;
    fade_state_t             state_nxt;
    logic [GAIN_W-1:0]       gain_nxt;
    logic                    muted_nxt;
    logic                    active_nxt;
    logic [RAMP_SHIFT-1:0]   prescaler;
    logic                    tick;
    logic                    go;

    assign go   = enable & ~terminate;
    assign tick = &prescaler;

    // Free-running prescaler; gain may only step when it wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + RAMP_SHIFT'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MUTE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a change of go always wins over a pending tick.
    always_comb begin
        state_nxt = state;
        case (state)
            MUTE: begin
                if (go) state_nxt = FADE_IN;
            end
            FADE_IN: begin
                if (!go) begin
                    state_nxt = FADE_OUT;
                end else if (tick && (gain >= GAIN_UNITY - 9'd1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!go) state_nxt = FADE_OUT;
            end
            FADE_OUT: begin
                if (go) begin
                    state_nxt = FADE_IN;
                end else if (tick && (gain <= 9'd1)) begin
                    state_nxt = MUTE;
                end
            end
            default: state_nxt = MUTE;
        endcase
    end

    // Gain ramp and status decodes; gain is clamped to 0..256 and frozen on direction changes.
    always_comb begin
        gain_nxt   = gain;
        muted_nxt  = (state_nxt == MUTE);
        active_nxt = (state_nxt == RUN);
        case (state)
            MUTE: begin
                gain_nxt = '0;
            end
            FADE_IN: begin
                if (go && tick) begin
                    gain_nxt = (gain >= GAIN_UNITY - 9'd1) ? GAIN_UNITY : gain + 9'd1;
                end
            end
            RUN: begin
                gain_nxt = GAIN_UNITY;
            end
            FADE_OUT: begin
                if (!go && tick) begin
                    gain_nxt = (gain <= 9'd1) ? '0 : gain - 9'd1;
                end
            end
            default: gain_nxt = '0;
        endcase
    end

    // Registered gain and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gain   <= '0;
            muted  <= 1'b1;
            active <= 1'b0;
        end else begin
            gain   <= gain_nxt;
            muted  <= muted_nxt;
            active <= active_nxt;
        end
    end

    audio_gain_channel u_chan_l (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_stb (sample_stb),
        .sample_in  (audio_l),
        .gain       (gain),
        .d_out      (d_l)
    );

    audio_gain_channel u_chan_r (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_stb (sample_stb),
        .sample_in  (audio_r),
        .gain       (gain),
        .d_out      (d_r)
    );

endmodule

// File: tb/tb_audio_fade_prep.sv
// Directed self-checking bench for audio_fade_prep with a short ramp.
module tb_audio_fade_prep;

    logic        clk;
    logic        reset_n;
    logic        sample_stb;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        enable;
    logic        terminate;
    logic [15:0] d_l;
    logic [15:0] d_r;
    logic [8:0]  gain;
    logic        muted;
    logic        active;

    int total = 0;
    int bad   = 0;
    int ncyc;

    audio_fade_prep #(.RAMP_SHIFT(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_stb (sample_stb),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .enable     (enable),
        .terminate  (terminate),
        .d_l        (d_l),
        .d_r        (d_r),
        .gain       (gain),
        .muted      (muted),
        .active     (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tog(input int n);
        repeat (n) begin
            enable = ~enable;
            @(negedge clk);
        end
    endtask

    task automatic wait_gain(input string tag, input logic [8:0] target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (gain === target) break;
            @(negedge clk);
        end
        chk(tag, 32'(gain), 32'(target));
    endtask

    // sel 0 waits for muted, sel 1 waits for active
    task automatic wait_flag(input string tag, input bit sel, input int bound, output int cycles);
        cycles = 0;
        for (int i = 0; i < bound; i++) begin
            if ((sel ? active : muted) === 1'b1) break;
            @(negedge clk);
            cycles++;
        end
        chk(tag, 32'(sel ? active : muted), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b1;
        sample_stb = 1'b0;
        audio_l    = '0;
        audio_r    = '0;
        enable     = 1'b0;
        terminate  = 1'b0;
        #3 reset_n = 1'b0;
        step(2);

        // reset state
        chk("rst_d_l",    32'(d_l),    32'h8000);
        chk("rst_d_r",    32'(d_r),    32'h8000);
        chk("rst_muted",  32'(muted),  32'd1);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_gain",   32'(gain),   32'd0);
        reset_n = 1'b1;

        // stays muted without enable
        step(1000);
        chk("idle_muted", 32'(muted), 32'd1);
        chk("idle_gain",  32'(gain),  32'd0);
        chk("idle_d_l",   32'(d_l),   32'h8000);

        // fade in with a strobed sample
        audio_l    = 16'h4000;
        audio_r    = 16'h2000;
        sample_stb = 1'b1;
        enable     = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        wait_gain("fi_gain10", 9'd10, 100);
        step(4);
        chk("fi_gain11", 32'(gain), 32'd11);
        step(4);
        chk("fi_gain12", 32'(gain), 32'd12);
        wait_gain("fi_gain128", 9'd128, 600);
        step(1);
        chk("half_d_l", 32'(d_l), 32'hA000);
        chk("half_d_r", 32'(d_r), 32'h9000);
        wait_flag("run_active", 1'b1, 700, ncyc);
        ncyc = ncyc + 512;
        chk("run_latency", 32'(ncyc >= 1020 && ncyc <= 1032), 32'd1);
        step(1);
        chk("run_d_l",  32'(d_l),  32'hC000);
        chk("run_d_r",  32'(d_r),  32'hA000);
        chk("run_gain", 32'(gain), 32'd256);

        // full-scale extremes at unity, two-edge latency
        audio_l    = 16'h8000;
        audio_r    = 16'h7FFF;
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        chk("lat1_d_l", 32'(d_l), 32'hC000);
        @(negedge clk);
        chk("ext_d_l", 32'(d_l), 32'h0000);
        chk("ext_d_r", 32'(d_r), 32'hFFFF);

        // fade out to 128 then freeze gain by toggling go every cycle
        enable = 1'b0;
        wait_gain("fo_gain128", 9'd128, 1200);
        audio_l    = 16'hFFFF;
        sample_stb = 1'b1;
        enable     = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        tog(3);
        chk("neg_half_d_l", 32'(d_l), 32'h7FFF);
        chk("neg_half_d_r", 32'(d_r), 32'hBFFF);
        chk("hold_gain_a",  32'(gain), 32'd128);
        audio_l    = 16'h0001;
        sample_stb = 1'b1;
        enable     = ~enable;
        @(negedge clk);
        sample_stb = 1'b0;
        tog(3);
        chk("pos_tiny_d_l", 32'(d_l), 32'h8000);
        chk("hold_gain_b",  32'(gain), 32'd128);

        // fade to mute, then fade in to 100 and terminate
        enable = 1'b0;
        wait_flag("mute_again", 1'b0, 700, ncyc);
        enable = 1'b1;
        wait_gain("fi_gain100", 9'd100, 600);
        terminate = 1'b1;
        step(1);
        chk("term_nojump", 32'(gain),   32'd100);
        chk("term_active", 32'(active), 32'd0);
        wait_gain("term_gain99", 9'd99, 8);
        wait_gain("term_gain98", 9'd98, 8);
        wait_flag("term_muted", 1'b0, 600, ncyc);
        step(1);
        chk("term_d_l", 32'(d_l), 32'h8000);
        chk("term_d_r", 32'(d_r), 32'h8000);
        step(50);
        chk("term_stays_muted", 32'(muted), 32'd1);
        chk("term_stays_gain",  32'(gain),  32'd0);

        // run again, then async reset mid-RUN
        terminate = 1'b0;
        wait_flag("run2_active", 1'b1, 1200, ncyc);
        step(2);
        chk("run2_d_l", 32'(d_l), 32'h8001);
        chk("run2_d_r", 32'(d_r), 32'hFFFF);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_d_l",    32'(d_l),    32'h8000);
        chk("arst_d_r",    32'(d_r),    32'h8000);
        chk("arst_gain",   32'(gain),   32'd0);
        chk("arst_muted",  32'(muted),  32'd1);
        chk("arst_active", 32'(active), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rel_muted", 32'(muted), 32'd1);
        step(1);
        chk("rel_fadein", 32'(muted), 32'd0);
        chk("rel_gain0",  32'(gain),  32'd0);
        wait_gain("rel_gain1", 9'd1, 8);
        chk("rel_d_l_quiet", 32'(d_l), 32'h8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
